// File: rtl/lsu_byte_sequencer_if.sv
// Bus bundle between the CPU memory stage, the load/store sequencer and the byte-wide data_mem.
// Port summary: req_* carry the CPU request (valid/ready), rsp_* the one-cycle completion pulse,
// mem_* the byte access to data_mem. The slave modport is the sequencer; master is the CPU/memory side.
interface lsu_byte_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // CPU request
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [2:0]            req_funct3_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  // CPU response
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  // data_mem byte port
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_we_o;
  logic [2:0]            mem_funct3_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_addr_o, mem_wdata_o, mem_we_o, mem_funct3_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_addr_o, mem_wdata_o, mem_we_o, mem_funct3_o
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer: splits LB/LH/LW/LBU/LHU/SB/SH/SW into one data_mem byte access per cycle
// and assembles load results with sign/zero extension. Latency: N byte cycles then a one-cycle
// rsp_valid_o pulse (N = 1/2/4); unsupported funct3 responds with rsp_err_o one cycle after accept.
// Backpressure: req_ready_o is high only when idle (busy_o = !req_ready_o stalls the pipeline);
// responses cannot be stalled. Ports: clk, rst_n_i (sync, active-low), bus (slave), busy_o.
module lsu_byte_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  lsu_byte_sequencer_if.slave   bus,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;       // current byte lane
  logic [DATA_WIDTH-1:0] asm_q, asm_d;       // load assembly register
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  // Only the low byte of the memory read port carries data.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^bus.mem_rdata_i[DATA_WIDTH-1:8];

  // Loads accept 000/001/010/100/101; stores only the signed encodings 000/001/010.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !we;
      default:                f3_legal = 1'b0;
    endcase
  endfunction

  // Index of the final byte; only reached for legal encodings (byte/half/word in f3[1:0]).
  function automatic logic [1:0] last_idx(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          we_d    = bus.req_we_i;
          f3_d    = bus.req_funct3_i;
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          cnt_d   = 2'd0;
          asm_d   = '0;
          err_d   = !f3_legal(bus.req_we_i, bus.req_funct3_i);
          // An unsupported request skips memory entirely and just reports the error.
          state_d = f3_legal(bus.req_we_i, bus.req_funct3_i) ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          asm_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata_i[7:0];
        end
        if (cnt_q == last_idx(f3_q)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode, purely from registered state
  logic                  ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  always_comb begin
    ready     = (state_q == IDLE);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (state_q == ACCESS) begin
      // Address wraps modulo 2^ADDR_WIDTH for misaligned accesses at the top of memory.
      mem_addr = addr_q + ADDR_WIDTH'(cnt_q);
      mem_we   = we_q;
      if (we_q) begin
        mem_wdata = {{(DATA_WIDTH-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
      end
    end
    if (state_q == DONE) begin
      rsp_valid = 1'b1;
      rsp_err   = err_q;
      if (!we_q && !err_q) begin
        case (f3_q)
          3'b000:  rsp_rdata = {{(DATA_WIDTH-8){asm_q[7]}}, asm_q[7:0]};
          3'b001:  rsp_rdata = {{(DATA_WIDTH-16){asm_q[15]}}, asm_q[15:0]};
          3'b100:  rsp_rdata = {{(DATA_WIDTH-8){1'b0}}, asm_q[7:0]};
          3'b101:  rsp_rdata = {{(DATA_WIDTH-16){1'b0}}, asm_q[15:0]};
          default: rsp_rdata = asm_q;
        endcase
      end
    end
  end

  assign bus.req_ready_o  = ready;
  assign busy_o           = !ready;
  assign bus.mem_we_o     = mem_we;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_wdata_o  = mem_wdata;
  assign bus.mem_funct3_o = mem_we ? 3'b000 : 3'b100;
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_rdata_o  = rsp_rdata;
  assign bus.rsp_err_o    = rsp_err;

  // State registers; reset aborts any operation in flight without a response.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
module tb_lsu_byte_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  lsu_byte_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  lsu_byte_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk     (clk),
    .rst_n_i (rst_n),
    .bus     (bus),
    .busy_o  (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit noise = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory as seen by the DUT, and the reference model's view of memory.
  logic [7:0] mem_d [logic [31:0]];
  logic [7:0] mem_m [logic [31:0]];

  function automatic logic [7:0] rd_d(input logic [31:0] a);
    return mem_d.exists(a) ? mem_d[a] : 8'h00;
  endfunction
  function automatic logic [7:0] rd_m(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : 8'h00;
  endfunction
  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    mem_m[a] = b;
    mem_d[a] = b;
  endtask

  // Synchronous byte write, asynchronous read (refreshed mid-cycle with junk in the upper bits).
  always @(posedge clk) if (bus.mem_we_o) mem_d[bus.mem_addr_o] = bus.mem_wdata_o[7:0];
  always @(negedge clk) bus.mem_rdata_i = {24'($urandom()), rd_d(bus.mem_addr_o)};

  typedef struct {int cyc; logic [31:0] addr; logic we; logic [7:0] wb;} acc_t;
  typedef struct {int cyc; logic [31:0] rdata; logic err;} rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  // Monitor: compares every cycle against the expectations queued at issue time.
  acc_t ma;
  rsp_t mr;
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_vs_ready", 32'(busy), 32'(!bus.req_ready_o));
      if (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
        ma = acc_q.pop_front();
        check("missed_access_cycle", cyc, ma.cyc);
      end
      if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
        ma = acc_q.pop_front();
        check("mem_addr", bus.mem_addr_o, ma.addr);
        check("mem_we", 32'(bus.mem_we_o), 32'(ma.we));
        check("mem_funct3", 32'(bus.mem_funct3_o), ma.we ? 32'd0 : 32'd4);
        if (ma.we) check("mem_wdata", bus.mem_wdata_o, {24'h0, ma.wb});
      end else begin
        check("quiet_mem_we", 32'(bus.mem_we_o), 32'd0);
        check("quiet_mem_addr", bus.mem_addr_o, 32'd0);
        check("quiet_mem_funct3", 32'(bus.mem_funct3_o), 32'd4);
      end
      if (bus.rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp_valid", 32'd1, 32'd0);
        end else begin
          mr = rsp_q.pop_front();
          check("rsp_cycle", cyc, mr.cyc);
          check("rsp_rdata", bus.rsp_rdata_o, mr.rdata);
          check("rsp_err", 32'(bus.rsp_err_o), 32'(mr.err));
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        mr = rsp_q.pop_front();
        check("missed_rsp_cycle", cyc, mr.cyc);
      end
    end
  end

  function automatic logic [31:0] ext(input logic [31:0] v, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'h0, v[7:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Issue one request (called at a negedge with the DUT idle) and queue the model's expectations.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int t, output int occ);
    int n;
    bit legal;
    logic [31:0] v;
    logic [31:0] a;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wdata;
    bus.req_valid_i  = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'($urandom());
    bus.req_funct3_i = 3'($urandom());
    bus.req_addr_i   = $urandom();
    bus.req_wdata_i  = $urandom();
    case (f3)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      3'b010:         n = 4;
      default:        n = 0;
    endcase
    legal = (n != 0) && !(we && f3[2]);
    if (!legal) begin
      rsp_q.push_back('{t, 32'h0, 1'b1});
      occ = 1;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        if (we) begin
          acc_q.push_back('{t + i, a, 1'b1, wdata[8*i +: 8]});
          mem_m[a] = wdata[8*i +: 8];
        end else begin
          acc_q.push_back('{t + i, a, 1'b0, 8'h00});
          v = v | (32'(rd_m(a)) << (8 * i));
        end
      end
      rsp_q.push_back('{t + n, we ? 32'h0 : ext(v, f3), 1'b0});
      occ = n + 1;
    end
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Wait for the DUT to become ready again; optionally wave junk requests while it is busy.
  task automatic wait_idle(input int t, input int occ);
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready_o || w >= 40) break;
      if (noise) begin
        bus.req_valid_i  = 1'($urandom());
        bus.req_we_i     = 1'($urandom());
        bus.req_funct3_i = 3'($urandom());
        bus.req_addr_i   = $urandom();
        bus.req_wdata_i  = $urandom();
      end
      w++;
    end
    bus.req_valid_i = 1'b0;
    if (!bus.req_ready_o) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout: req_ready_o still 0 after 40 cycles, expected 1");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "DUT stuck busy");
    end
    check("ready_return_cycle", cyc, t + occ);
  endtask

  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wdata);
    int t;
    int occ;
    issue(we, f3, addr, wdata, t, occ);
    wait_idle(t, occ);
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata_o, 32'd0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err_o), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we_o), 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr_o, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'd0);
    check({tag, "_mem_funct3"}, 32'(bus.mem_funct3_o), 32'd4);
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int occ;
    logic [7:0] old3;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'b000;
    bus.req_addr_i   = 32'h0;
    bus.req_wdata_i  = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    mon_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");

    // LW of 11,22,33,44 -> 0x44332211
    poke(32'h10000, 8'h11); poke(32'h10001, 8'h22);
    poke(32'h10002, 8'h33); poke(32'h10003, 8'h44);
    op(1'b0, 3'b010, 32'h10000, 32'h0);
    // LB / LBU of 0x80
    poke(32'h10010, 8'h80);
    op(1'b0, 3'b000, 32'h10010, 32'h0);
    op(1'b0, 3'b100, 32'h10010, 32'h0);
    // Misaligned LHU and signed LH
    poke(32'h10003, 8'hCD); poke(32'h10004, 8'hAB);
    op(1'b0, 3'b101, 32'h10003, 32'h0);
    poke(32'h10020, 8'h00); poke(32'h10021, 8'h80);
    op(1'b0, 3'b001, 32'h10020, 32'h0);
    // SW then read back through the DUT
    op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    check("sw_byte0", 32'(rd_d(32'h100)), 32'hEF);
    check("sw_byte1", 32'(rd_d(32'h101)), 32'hBE);
    check("sw_byte2", 32'(rd_d(32'h102)), 32'hAD);
    check("sw_byte3", 32'(rd_d(32'h103)), 32'hDE);
    op(1'b0, 3'b010, 32'h100, 32'h0);
    // Unsupported encodings
    op(1'b0, 3'b011, 32'h200, 32'h0);
    op(1'b1, 3'b011, 32'h200, 32'h12345678);
    op(1'b1, 3'b100, 32'h200, 32'h12345678);
    op(1'b1, 3'b101, 32'h200, 32'h12345678);
    op(1'b0, 3'b110, 32'h200, 32'h0);
    op(1'b0, 3'b111, 32'h200, 32'h0);
    check("illegal_no_write", 32'(mem_d.exists(32'h200)), 32'd0);
    // SH across the top of the address space
    op(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000A55A);
    check("wrap_byte_hi", 32'(rd_d(32'hFFFFFFFF)), 32'h5A);
    check("wrap_byte_lo", 32'(rd_d(32'h00000000)), 32'hA5);
    op(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);

    // Reset during the third byte of an SW
    poke(32'h3003, 8'h5A);
    old3 = rd_m(32'h3003);
    issue(1'b1, 3'b010, 32'h3000, 32'h11223344, t, occ);
    repeat (3) @(negedge clk);
    check("abort_third_byte_addr", bus.mem_addr_o, 32'h3002);
    rst_n = 1'b0;
    while (acc_q.size() > 0 && acc_q[$].cyc > t + 2) void'(acc_q.pop_back());
    rsp_q.delete();
    @(negedge clk);
    chk_quiet("abort");
    mem_m.delete(32'h3002);
    mem_d.delete(32'h3002);
    mem_m[32'h3003] = old3;
    check("abort_byte0_kept", 32'(rd_d(32'h3000)), 32'h44);
    check("abort_byte1_kept", 32'(rd_d(32'h3001)), 32'h33);
    check("abort_byte3_untouched", 32'(rd_d(32'h3003)), 32'h5A);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_quiet("abort_release");
    op(1'b0, 3'b001, 32'h3000, 32'h0);

    // Randomized traffic, with junk requests waved while busy
    for (int a = 0; a < 72; a++) poke(32'h2000 + 32'(a), 8'($urandom()));
    for (int a = 0; a < 8; a++) begin
      poke(32'hFFFFFFF8 + 32'(a), 8'($urandom()));
      poke(32'h0 + 32'(a), 8'($urandom()));
    end
    noise = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      logic rwe;
      logic [2:0] rf3;
      rwe = 1'($urandom());
      rf3 = 3'($urandom());
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else ra = 32'h2000 + 32'($urandom_range(0, 63));
      op(rwe, rf3, ra, $urandom());
    end
    noise = 1'b0;
    repeat (4) @(negedge clk);

    check("acc_queue_drained", acc_q.size(), 32'd0);
    check("rsp_queue_drained", rsp_q.size(), 32'd0);
    foreach (mem_m[k]) check("mem_final_model", 32'(rd_d(k)), 32'(mem_m[k]));
    foreach (mem_d[k]) check("mem_final_dut", 32'(mem_d[k]), 32'(rd_m(k)));
    finish_run();
  end

endmodule
